// File: rtl/baud_gen_pkg.sv
// Shared types and constants for the fractional baud generator: FSM state,
// standard baud rates and the clock-to-divisor helper.
package baud_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RELOAD = 2'd1,
        ST_RUN    = 2'd2
    } baud_state_e;

    localparam longint unsigned BAUD_9600   = 64'd9600;
    localparam longint unsigned BAUD_19200  = 64'd19200;
    localparam longint unsigned BAUD_115200 = 64'd115200;
    localparam longint unsigned BAUD_256000 = 64'd256000;

    localparam longint unsigned DEFAULT_CLK_FREQ_HZ = 64'd50_000_000;
    localparam longint unsigned DEFAULT_OVERSAMPLE  = 64'd16;
    localparam int unsigned     DEFAULT_FRAC_WIDTH  = 4;

    // Combined divisor {int,frac} in units of 1/2^frac_width cycle, rounded down.
    function automatic longint unsigned calc_divisor(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned oversample,
        input int unsigned     frac_width
    );
        return (clk_hz << frac_width) / (baud * oversample);
    endfunction

    localparam longint unsigned DEFAULT_DIVISOR =
        calc_divisor(DEFAULT_CLK_FREQ_HZ, BAUD_9600, DEFAULT_OVERSAMPLE, DEFAULT_FRAC_WIDTH);
    localparam int unsigned DEFAULT_DIV_INT  = int'(DEFAULT_DIVISOR >> DEFAULT_FRAC_WIDTH);
    localparam int unsigned DEFAULT_DIV_FRAC = int'(DEFAULT_DIVISOR & ((64'd1 << DEFAULT_FRAC_WIDTH) - 64'd1));

endpackage

// File: rtl/baud_generator_frac_period.sv
// frac_period_counter: sample-period down-counter with a fractional accumulator
// that stretches a period by one cycle whenever its closing accumulation carries.
module frac_period_counter #(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              run_i,
    input  logic [INT_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              tick_o
);

    logic [INT_W-1:0]  cnt_q;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_next;
    logic              long_period;

    // The upcoming period is long when the accumulation that will end it
    // carries out; a + b overflows exactly when a > ~b.
    always_comb begin
        acc_next    = acc_q + div_frac_i;
        long_period = (acc_next > ~div_frac_i);
    end

    assign tick_o = run_i && (cnt_q == '0);

    // Load value is one short because the cycle of the load itself counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (load_i) begin
            cnt_q <= div_int_i - INT_W'(2);
            acc_q <= '0;
        end else if (tick_o) begin
            cnt_q <= div_int_i - INT_W'(1) + INT_W'(long_period);
            acc_q <= acc_next;
        end else if (run_i) begin
            cnt_q <= cnt_q - INT_W'(1);
        end
    end

endmodule

// File: rtl/baud_generator_frac.sv
// Fractional baud generator: registered oversample and bit strobes from a
// runtime divisor. Define BAUD_GEN_PRESET_EN to add the preset-table ports.
module baud_generator_frac
    import baud_gen_pkg::*;
#(
    parameter int unsigned TOP_CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE      = 16,
    parameter int unsigned DIV_INT_WIDTH   = 16,
    parameter int unsigned DIV_FRAC_WIDTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [DIV_INT_WIDTH-1:0]  div_int_i,
    input  logic [DIV_FRAC_WIDTH-1:0] div_frac_i,
    output logic                      sample_en_o,
    output logic                      bit_en_o,
    output logic [DIV_INT_WIDTH-1:0]  div_int_o,
    output logic [DIV_FRAC_WIDTH-1:0] div_frac_o,
`ifdef BAUD_GEN_PRESET_EN
    input  logic                      preset_use_i,
    input  logic [1:0]                preset_sel_i,
`endif
    output baud_state_e               state_o
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    localparam longint unsigned RST_DIVISOR =
        calc_divisor(TOP_CLK_FREQ_HZ, BAUD_9600, OVERSAMPLE, DIV_FRAC_WIDTH);
    localparam logic [DIV_INT_WIDTH-1:0]  RST_DIV_INT  = DIV_INT_WIDTH'(RST_DIVISOR >> DIV_FRAC_WIDTH);
    localparam logic [DIV_FRAC_WIDTH-1:0] RST_DIV_FRAC = DIV_FRAC_WIDTH'(RST_DIVISOR);
    localparam logic [DIV_INT_WIDTH-1:0]  MIN_DIV_INT  = DIV_INT_WIDTH'(2);

`ifdef BAUD_GEN_PRESET_EN
    localparam longint unsigned PRE_DIV_0 = calc_divisor(TOP_CLK_FREQ_HZ, BAUD_9600,   OVERSAMPLE, DIV_FRAC_WIDTH);
    localparam longint unsigned PRE_DIV_1 = calc_divisor(TOP_CLK_FREQ_HZ, BAUD_19200,  OVERSAMPLE, DIV_FRAC_WIDTH);
    localparam longint unsigned PRE_DIV_2 = calc_divisor(TOP_CLK_FREQ_HZ, BAUD_115200, OVERSAMPLE, DIV_FRAC_WIDTH);
    localparam longint unsigned PRE_DIV_3 = calc_divisor(TOP_CLK_FREQ_HZ, BAUD_256000, OVERSAMPLE, DIV_FRAC_WIDTH);
`endif

    baud_state_e               state_q, state_d;
    logic [DIV_INT_WIDTH-1:0]  div_int_q;
    logic [DIV_FRAC_WIDTH-1:0] div_frac_q;
    logic [DIV_INT_WIDTH-1:0]  req_int;
    logic [DIV_FRAC_WIDTH-1:0] req_frac;
    logic [DIV_INT_WIDTH-1:0]  req_int_clamped;
    logic [OS_W-1:0]           os_cnt_q;
    logic                      sample_en_q;
    logic                      bit_en_q;
    logic                      cfg_accept;
    logic                      tick;

    // Handshake: a divisor transfers on any edge where cfg_valid_i && cfg_ready_o;
    // ready drops only during the single RELOAD cycle, valid may be held freely.
    assign cfg_ready_o = (state_q != ST_RELOAD);
    assign cfg_accept  = cfg_valid_i && cfg_ready_o;

    always_comb begin
        req_int  = div_int_i;
        req_frac = div_frac_i;
`ifdef BAUD_GEN_PRESET_EN
        if (preset_use_i) begin
            unique case (preset_sel_i)
                2'b00: begin req_int = DIV_INT_WIDTH'(PRE_DIV_0 >> DIV_FRAC_WIDTH); req_frac = DIV_FRAC_WIDTH'(PRE_DIV_0); end
                2'b01: begin req_int = DIV_INT_WIDTH'(PRE_DIV_1 >> DIV_FRAC_WIDTH); req_frac = DIV_FRAC_WIDTH'(PRE_DIV_1); end
                2'b10: begin req_int = DIV_INT_WIDTH'(PRE_DIV_2 >> DIV_FRAC_WIDTH); req_frac = DIV_FRAC_WIDTH'(PRE_DIV_2); end
                2'b11: begin req_int = DIV_INT_WIDTH'(PRE_DIV_3 >> DIV_FRAC_WIDTH); req_frac = DIV_FRAC_WIDTH'(PRE_DIV_3); end
            endcase
        end
`endif
        req_int_clamped = (req_int < MIN_DIV_INT) ? MIN_DIV_INT : req_int;
    end

    // Dropping enable wins over an accept; the divisor is still captured below.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_RELOAD;
            ST_RELOAD: state_d = enable_i ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (!enable_i)       state_d = ST_IDLE;
                else if (cfg_accept) state_d = ST_RELOAD;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    frac_period_counter #(
        .INT_W  (DIV_INT_WIDTH),
        .FRAC_W (DIV_FRAC_WIDTH)
    ) u_period (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (state_q == ST_IDLE),
        .load_i     (state_q == ST_RELOAD),
        .run_i      (state_q == ST_RUN),
        .div_int_i  (div_int_q),
        .div_frac_i (div_frac_q),
        .tick_o     (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            div_int_q   <= RST_DIV_INT;
            div_frac_q  <= RST_DIV_FRAC;
            os_cnt_q    <= '0;
            sample_en_q <= 1'b0;
            bit_en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_accept) begin
                div_int_q  <= req_int_clamped;
                div_frac_q <= req_frac;
            end
            // A tick on the edge that leaves RUN is dropped so IDLE/RELOAD stay quiet.
            sample_en_q <= tick && (state_d == ST_RUN);
            bit_en_q    <= tick && (state_d == ST_RUN) && (os_cnt_q == OS_LAST);
            if (state_q != ST_RUN) begin
                os_cnt_q <= '0;
            end else if (tick) begin
                os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
            end
        end
    end

    assign sample_en_o = sample_en_q;
    assign bit_en_o    = bit_en_q;
    assign div_int_o   = div_int_q;
    assign div_frac_o  = div_frac_q;
    assign state_o     = state_q;

endmodule
